// File: rtl/data_memory_line_pkg.sv
// Shared memory-interface constants for the data cache and its backing line memory.
// The cache side uses the same line width and offset width.
package data_memory_line_pkg;

    localparam int LINE_W          = 256;
    localparam int OFFSET_W        = 5;
    localparam int DEFAULT_LATENCY = 10;
    localparam int CNT_W           = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/data_memory_array.sv
// Single-port synchronous line RAM with write-enable and a registered read port.
// The read register only loads on a read access, so it holds the last line read.
module data_memory_array
    import data_memory_line_pkg::*;
#(
    parameter int IDX_W = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] mem [2**IDX_W];
    logic [LINE_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            mem[idx_i] <= wdata_i;
        end
    end

    // Contents are never reset; only the read register clears.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_line.sv
// Line-granular backing data memory with a fixed access latency and a one-cycle ack pulse.
// Requests are latched on acceptance; the array access happens on the edge that enters ACK.
module data_memory_line
    import data_memory_line_pkg::*;
#(
    parameter int IDX_W   = 9,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               wr_q, wr_d;
    logic [LINE_W-1:0]  wdata_q, wdata_d;
    logic               mem_en;
    logic               unused_addr;

    assign unused_addr = ^{addr_i[31:OFFSET_W+IDX_W], addr_i[OFFSET_W-1:0]};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end

    // LATENCY = 1 loads a zero count, so BUSY completes on the very next edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    idx_d   = addr_i[OFFSET_W+IDX_W-1:OFFSET_W];
                    wr_d    = write_i;
                    wdata_d = data_i;
                    cnt_d   = LAT_M1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_en = (state_q == BUSY) && (cnt_q == '0);
    assign ack_o  = (state_q == ACK);

    data_memory_array #(
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (mem_en),
        .we_i    (wr_q),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (data_o)
    );

endmodule

// File: tb/tb_data_memory_line.sv
// Directed bench for data_memory_line: a LATENCY=10 instance plus a LATENCY=1 instance.
module tb_data_memory_line;

    logic         clk;
    logic         rstN;
    logic         enable, write;
    logic [31:0]  addr;
    logic [255:0] dataIn;
    logic         ack;
    logic [255:0] dataOut;
    logic         enable1, write1;
    logic [31:0]  addr1;
    logic [255:0] dataIn1;
    logic         ack1;
    logic [255:0] dataOut1;

    int checks   = 0;
    int failures = 0;

    data_memory_line #(.IDX_W(9), .LATENCY(10)) dut (
        .clk_i(clk), .rst_i(rstN), .enable_i(enable), .write_i(write),
        .addr_i(addr), .data_i(dataIn), .ack_o(ack), .data_o(dataOut)
    );

    data_memory_line #(.IDX_W(9), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rstN), .enable_i(enable1), .write_i(write1),
        .addr_i(addr1), .data_i(dataIn1), .ack_o(ack1), .data_o(dataOut1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!ack && n < 40);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [255:0] d, output int lat);
        enable = 1'b1; write = 1'b0; addr = a;
        tick();
        wait_ack(lat);
        d = dataOut;
        enable = 1'b0;
        tick();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [255:0] d, output int lat);
        enable = 1'b1; write = 1'b1; addr = a; dataIn = d;
        tick();
        wait_ack(lat);
        enable = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        enable = 0; write = 0; addr = '0; dataIn = '0;
        enable1 = 0; write1 = 0; addr1 = '0; dataIn1 = '0;
        #3;
        checks++;
        if (ack !== 1'b0 || dataOut !== '0) begin
            failures++;
            $display("[TB] FAIL reset_state: ack=%b data=%h expected ack=0 data=0", ack, dataOut);
        end
        checks++;
        if (ack1 !== 1'b0 || dataOut1 !== '0) begin
            failures++;
            $display("[TB] FAIL reset_state_lat1: ack=%b data=%h expected ack=0 data=0", ack1, dataOut1);
        end
        tick(); tick();
        rstN = 1'b1;
        tick();
    endtask

    task automatic test_read_preload();
        logic [255:0] exp = {8{32'hA5A5_0003}};
        dut.u_array.mem[3] = exp;
        enable = 1'b1; write = 1'b0; addr = 32'h0000_0060;
        tick();
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (ack !== 1'b0) begin
                failures++;
                $display("[TB] FAIL read_ack_early: cycle %0d ack=%b expected 0", c, ack);
            end
            if (c < 9) tick();
        end
        tick();
        enable = 1'b0;
        checks++;
        if (ack !== 1'b1 || dataOut !== exp) begin
            failures++;
            $display("[TB] FAIL read_ack_c10: ack=%b data=%h expected ack=1 data=%h", ack, dataOut, exp);
        end
        tick();
        checks++;
        if (ack !== 1'b0) begin
            failures++;
            $display("[TB] FAIL read_ack_c11: ack=%b expected 0", ack);
        end
    endtask

    task automatic test_write_then_read();
        logic [255:0] exp = {8{32'hDEAD_BEEF}};
        logic [255:0] got;
        int lat;
        do_write(32'h0000_00E0, exp, lat);
        checks++;
        if (lat !== 10) begin
            failures++;
            $display("[TB] FAIL write_latency: got %0d expected 10", lat);
        end
        do_read(32'h0000_00E0, got, lat);
        checks++;
        if (lat !== 10 || got !== exp) begin
            failures++;
            $display("[TB] FAIL write_then_read: lat=%0d data=%h expected lat=10 data=%h", lat, got, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] wv = {8{32'h1234_5678}};
        logic [255:0] rv = {8{32'h0000_0040}};
        logic [255:0] got;
        int lat;
        int extraAcks = 0;
        dut.u_array.mem[64] = rv;
        enable = 1'b1; write = 1'b1; addr = 32'h0000_0400; dataIn = wv;
        tick();
        for (int c = 1; c <= 10; c++) tick();
        checks++;
        if (ack !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_first_ack: ack=%b expected 1 at cycle 10", ack);
        end
        write = 1'b0; addr = 32'h0000_0800;
        for (int c = 11; c <= 21; c++) begin
            tick();
            if (ack) extraAcks++;
        end
        checks++;
        if (extraAcks !== 0) begin
            failures++;
            $display("[TB] FAIL b2b_gap: acks=%0d expected 0 in cycles 11..21", extraAcks);
        end
        tick();
        enable = 1'b0;
        checks++;
        if (ack !== 1'b1 || dataOut !== rv) begin
            failures++;
            $display("[TB] FAIL b2b_refill_c22: ack=%b data=%h expected ack=1 data=%h", ack, dataOut, rv);
        end
        tick();
        do_read(32'h0000_0400, got, lat);
        checks++;
        if (got !== wv) begin
            failures++;
            $display("[TB] FAIL b2b_writeback_line32: data=%h expected %h", got, wv);
        end
    endtask

    task automatic test_alias_and_drop();
        logic [255:0] exp = {8{32'hA5A5_0003}};
        int n;
        enable = 1'b1; write = 1'b0; addr = 32'h0000_8060;
        tick();
        tick(); tick();
        enable = 1'b0;
        wait_ack(n);
        checks++;
        if (n + 2 !== 10 || dataOut !== exp) begin
            failures++;
            $display("[TB] FAIL alias_drop_enable: lat=%0d data=%h expected lat=10 data=%h", n + 2, dataOut, exp);
        end
        tick();
    endtask

    task automatic test_input_stability();
        logic [255:0] wv = {8{32'hCAFE_0005}};
        logic [255:0] pv = {8{32'h6666_6666}};
        logic [255:0] got;
        int lat;
        int ackCount = 0;
        int ackCycle = -1;
        dut.u_array.mem[6] = pv;
        enable = 1'b1; write = 1'b1; addr = 32'h0000_00A0; dataIn = wv;
        tick();
        for (int c = 1; c <= 11; c++) begin
            addr = 32'h0000_00C0 + 32'(c * 32);
            dataIn = {8{32'(c)}};
            if (c == 11) enable = 1'b0;
            tick();
            if (ack) begin
                ackCount++;
                ackCycle = c;
            end
            if (c == 1) addr = 32'h0000_00C0;
        end
        checks++;
        if (ackCount !== 1 || ackCycle !== 10) begin
            failures++;
            $display("[TB] FAIL stability_acks: count=%0d cycle=%0d expected 1 at 10", ackCount, ackCycle);
        end
        tick();
        do_read(32'h0000_00A0, got, lat);
        checks++;
        if (got !== wv) begin
            failures++;
            $display("[TB] FAIL stability_latched_data: data=%h expected %h", got, wv);
        end
        do_read(32'h0000_00C0, got, lat);
        checks++;
        if (got !== pv) begin
            failures++;
            $display("[TB] FAIL stability_other_line: data=%h expected %h", got, pv);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [255:0] got;
        int lat;
        int ackCount = 0;
        dut.u_array.mem[9] = 256'h1;
        enable = 1'b1; write = 1'b1; addr = 32'h0000_0120; dataIn = '1;
        tick();
        for (int c = 1; c <= 5; c++) tick();
        rstN = 1'b0;
        enable = 1'b0;
        #1;
        checks++;
        if (ack !== 1'b0 || dataOut !== '0) begin
            failures++;
            $display("[TB] FAIL reset_mid_write_outputs: ack=%b data=%h expected ack=0 data=0", ack, dataOut);
        end
        tick(); tick();
        rstN = 1'b1;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (ack) ackCount++;
        end
        checks++;
        if (ackCount !== 0 || dataOut !== '0) begin
            failures++;
            $display("[TB] FAIL reset_mid_write_noack: acks=%0d data=%h expected 0 acks data=0", ackCount, dataOut);
        end
        do_read(32'h0000_0120, got, lat);
        checks++;
        if (got !== 256'h1 || lat !== 10) begin
            failures++;
            $display("[TB] FAIL reset_mid_write_line9: data=%h lat=%0d expected data=1 lat=10", got, lat);
        end
    endtask

    task automatic test_latency_one();
        logic [255:0] exp = {8{32'h1111_2222}};
        logic         expAck [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        dut1.u_array.mem[2] = exp;
        enable1 = 1'b1; write1 = 1'b0; addr1 = 32'h0000_0040;
        for (int c = 0; c <= 4; c++) begin
            tick();
            if (c == 4) enable1 = 1'b0;
            checks++;
            if (ack1 !== expAck[c]) begin
                failures++;
                $display("[TB] FAIL lat1_ack: cycle %0d ack=%b expected %b", c, ack1, expAck[c]);
            end
            if (c == 1) begin
                checks++;
                if (dataOut1 !== exp) begin
                    failures++;
                    $display("[TB] FAIL lat1_data: data=%h expected %h", dataOut1, exp);
                end
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_read_preload();
        test_write_then_read();
        test_back_to_back();
        test_alias_and_drop();
        test_input_stability();
        test_reset_mid_write();
        test_latency_one();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
